regbank_writer: RTL and testbench
=================================

Name: regbank_writer

Overview:
- Write side of the 16-word x 16-bit register bank whose read side is the 16:1 word multiplexer.
- Accepts write requests over a valid/ready handshake, decodes the 4-bit address into one-hot enables and updates the addressed register.
- Provides a sequenced clear-all operation.
- Exposes every register on a flattened bus that feeds the mux data inputs.

Parameters:
- DATA_W, 16, width of each register in bits.
- NUM_REGS, 12, number of implemented registers (1..16); addresses >= NUM_REGS are out of range.
- ADDR_W, 4, address width; fixed at 4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- wr_valid  in  1  write request valid.
- wr_ready  out  1  block can accept a write this cycle.
- wr_addr  in  ADDR_W  target register index; bit 0 corresponds to mux select S0.
- wr_data  in  DATA_W  write data.
- clear_req  in  1  single-cycle request to zero all registers.
- busy  out  1  clear sweep in progress.
- clear_done  out  1  one-cycle pulse when the sweep finishes.
- wr_err  out  1  one-cycle pulse when an accepted write had an out-of-range address.
- wr_onehot  out  16  registered one-hot write enable of the last write cycle, for debug.
- regs_o  out  16*DATA_W  register contents; word i at bits [i*DATA_W +: DATA_W]; words >= NUM_REGS read as 0.

Behaviour:
- Reset (rst_n low, asynchronous): all registers = 0, FSM = IDLE, wr_ready = 0 while in reset, busy = 0, clear_done = 0, wr_err = 0, wr_onehot = 0.
- wr_ready = (state == IDLE) && !clear_req. It is combinational from state and clear_req.
- Handshake:
  - A write is accepted in any cycle where wr_valid && wr_ready.
  - wr_addr and wr_data are sampled on that edge.
  - The new value appears on regs_o in the following cycle (1-cycle latency).
  - The source must hold valid, addr and data stable until accepted.
- Address decode:
  - In range (addr < NUM_REGS): only that register is written; wr_onehot = 1 << addr for one cycle.
  - Out of range: no register changes; wr_onehot = 0; wr_err pulses for one cycle after acceptance.
  - Out-of-range writes are still accepted, so the handshake never stalls on a bad address.
- Back-to-back writes: one write per cycle. Two consecutive writes to the same address leave the last data.
- FSM states:
  - IDLE: accept writes. clear_req=1 -> CLEAR with idx = 0. clear_req has priority over a simultaneous wr_valid; that write is not accepted and stays pending.
  - CLEAR: busy=1, wr_ready=0. Each cycle, register idx is set to 0 and idx increments. At idx == NUM_REGS-1: clear that register, pulse clear_done, return to IDLE.
  - Sweep length is exactly NUM_REGS cycles.
- clear_req while in CLEAR is ignored; the sweep does not restart.
- Reset asserted mid-sweep: immediate return to IDLE with all registers 0; no clear_done pulse.
- During CLEAR, registers not yet swept hold their old values and are visible on regs_o.

Optional Feature:
- Macro: REGBANK_BYTE_EN.
- When defined:
  - Adds input wr_be [DATA_W/8] (2 bits at default width).
  - An accepted in-range write updates only the bytes whose enable is 1.
  - wr_be = 0 is a legal no-op write; wr_onehot still asserts.
  - DATA_W must be a multiple of 8.
- When undefined: no wr_be port; every accepted write updates the full word.

Decomposition:
- Shared package regbank_pkg holds:
  - DATA_W_DEF = 16, MAX_REGS = 16, ADDR_W = 4.
  - FSM state enum {ST_IDLE, ST_CLEAR}.
  - Helper function onehot16(addr) returning a 16-bit enable.
- One sub-module is natural: regbank_dec4to16, a combinational 4-to-16 one-hot decoder with enable input. It is the inverse of the read-side select tree and is used for the write enables.

Test Plan:
- Reset release, then write addr 3 data 16'hA5A5 -> next cycle regs_o word 3 = A5A5, all other words 0, wr_onehot = 16'h0008.
- Writes to addr 0..11 with data 16'h1000+i on consecutive cycles with wr_valid held high -> wr_ready stays 1, each word i = 1000+i, one acceptance per cycle.
- Write addr 13 data 16'hFFFF (NUM_REGS=12) -> accepted, wr_err pulses once, wr_onehot = 0, regs_o unchanged, word 13 reads 0.
- Fill all registers, then pulse clear_req in the same cycle as wr_valid to addr 5:
  - Required: busy high for 12 cycles, word k = 0 after sweep cycle k, clear_done pulses on cycle 12.
  - The pending write to addr 5 is accepted in the first cycle back in IDLE, and word 5 then holds the new data.
- Assert rst_n low at sweep cycle 6 -> all words 0 immediately, busy = 0, no clear_done pulse; after release, wr_ready = 1.
- With REGBANK_BYTE_EN: word 2 = 16'h1234, write 16'hABCD with wr_be = 2'b10 -> word 2 = 16'hAB34; wr_be = 2'b00 -> word 2 unchanged.

Source files
------------

// File: rtl/regbank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regbank_pkg
// Purpose  : Shared constants, FSM state type and one-hot helper for the
//            write side of the 16-word register bank.
// Contents : DATA_W_DEF - default register width
//            MAX_REGS   - physical word slots on the flattened output bus
//            ADDR_W     - register index width (fixed at 4)
//            state_e    - writer FSM states
//            onehot16   - 4-bit index to 16-bit one-hot enable
// Revision : 1.0 - initial release
// ============================================================================
package regbank_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int MAX_REGS   = 16;
  localparam int ADDR_W     = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  function automatic logic [MAX_REGS-1:0] onehot16(input logic [ADDR_W-1:0] addr);
    onehot16 = {{(MAX_REGS-1){1'b0}}, 1'b1} << addr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regbank_dec4to16.sv
`default_nettype none
// ============================================================================
// Module   : regbank_dec4to16
// Purpose  : Combinational 4-to-16 one-hot decoder with enable; generates the
//            per-word write strobes (inverse of the read-side select tree).
// Ports    : addr   in  4   word index, bit 0 = mux select S0
//            en     in  1   decoder enable; all outputs low when 0
//            onehot out 16  one-hot word enable
// Revision : 1.0 - initial release
// ============================================================================
module regbank_dec4to16 (
  input  logic [3:0]  addr,
  input  logic        en,
  output logic [15:0] onehot
);
  import regbank_pkg::*;

  assign onehot = en ? onehot16(addr) : 16'h0000;

endmodule
`default_nettype wire

// File: rtl/regbank_writer.sv
`default_nettype none
// ============================================================================
// Module   : regbank_writer
// Purpose  : Write side of the 16-word register bank. Valid/ready write port,
//            one-hot address decode, sequenced clear-all sweep and a
//            flattened view of every word for the read multiplexer.
// Ports    : clk        in   1          rising-edge clock
//            rst_n      in   1          asynchronous active-low reset
//            wr_valid   in   1          write request valid
//            wr_ready   out  1          write can be accepted this cycle
//            wr_addr    in   ADDR_W     target word index
//            wr_data    in   DATA_W     write data
//            wr_be      in   DATA_W/8   byte enables (REGBANK_BYTE_EN only)
//            clear_req  in   1          request to zero all words
//            busy       out  1          clear sweep in progress
//            clear_done out  1          pulse when the sweep completes
//            wr_err     out  1          pulse after an out-of-range write
//            wr_onehot  out  16         registered write enable, debug
//            regs_o     out  16*DATA_W  word i at [i*DATA_W +: DATA_W]
// Options  : `define REGBANK_BYTE_EN adds the wr_be byte-enable input.
// Revision : 1.0 - initial release
// ============================================================================
module regbank_writer #(
  parameter int DATA_W   = regbank_pkg::DATA_W_DEF,
  parameter int NUM_REGS = 12,
  parameter int ADDR_W   = regbank_pkg::ADDR_W
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  wr_valid,
  output logic                                  wr_ready,
  input  logic [ADDR_W-1:0]                     wr_addr,
  input  logic [DATA_W-1:0]                     wr_data,
`ifdef REGBANK_BYTE_EN
  input  logic [DATA_W/8-1:0]                   wr_be,
`endif
  input  logic                                  clear_req,
  output logic                                  busy,
  output logic                                  clear_done,
  output logic                                  wr_err,
  output logic [regbank_pkg::MAX_REGS-1:0]        wr_onehot,
  output logic [regbank_pkg::MAX_REGS*DATA_W-1:0] regs_o
);
  import regbank_pkg::*;

  localparam logic [ADDR_W:0]   c_num_regs = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] c_last_idx = ADDR_W'(NUM_REGS-1);

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0]     regs_q [NUM_REGS];
  logic [DATA_W-1:0]     regs_d [NUM_REGS];
  logic                  clear_done_q, clear_done_d;
  logic                  wr_err_q, wr_err_d;
  logic [MAX_REGS-1:0]   wr_onehot_q, wr_onehot_d;

  logic                  wr_accept;
  logic                  wr_in_range;
  logic [MAX_REGS-1:0]   wr_en;
  logic [DATA_W-1:0]     wr_mask;

  // rst_n gates ready so no handshake can complete while the bank is held
  // in reset, even though the state register already reads IDLE.
  assign wr_ready    = rst_n && (state_q == ST_IDLE) && !clear_req;
  assign wr_accept   = wr_valid && wr_ready;
  assign wr_in_range = {1'b0, wr_addr} < c_num_regs;
  assign busy        = (state_q == ST_CLEAR);

  // Out-of-range writes still complete the handshake but never reach a
  // word, so the decoder is only enabled for valid indices.
  regbank_dec4to16 u_dec (
    .addr   (wr_addr),
    .en     (wr_accept && wr_in_range),
    .onehot (wr_en)
  );

`ifdef REGBANK_BYTE_EN
  always_comb begin
    wr_mask = '0;
    for (int b = 0; b < DATA_W/8; b++) begin
      wr_mask[b*8 +: 8] = {8{wr_be[b]}};
    end
  end
`else
  assign wr_mask = '1;
`endif

  // Sweep sequencer: one word per cycle, exactly NUM_REGS cycles.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    clear_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (idx_q == c_last_idx) begin
          state_d      = ST_IDLE;
          idx_d        = '0;
          clear_done_d = 1'b1;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // wr_en is only non-zero in IDLE, so sweep and write never collide.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if ((state_q == ST_CLEAR) && (idx_q == ADDR_W'(i))) begin
        regs_d[i] = '0;
      end else if (wr_en[i]) begin
        regs_d[i] = (regs_q[i] & ~wr_mask) | (wr_data & wr_mask);
      end
    end
  end

  always_comb begin
    wr_err_d    = wr_accept && !wr_in_range;
    wr_onehot_d = wr_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      clear_done_q <= 1'b0;
      wr_err_q     <= 1'b0;
      wr_onehot_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      clear_done_q <= clear_done_d;
      wr_err_q     <= wr_err_d;
      wr_onehot_q  <= wr_onehot_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign clear_done = clear_done_q;
  assign wr_err     = wr_err_q;
  assign wr_onehot  = wr_onehot_q;

  // Unimplemented word slots read as zero on the flattened bus.
  for (genvar g = 0; g < MAX_REGS; g++) begin : g_word
    if (g < NUM_REGS) begin : g_impl
      assign regs_o[g*DATA_W +: DATA_W] = regs_q[g];
    end else begin : g_empty
      assign regs_o[g*DATA_W +: DATA_W] = '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regbank_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_regbank_writer
// Purpose  : Self-checking bench for regbank_writer (DATA_W=16, NUM_REGS=12).
//            A word-array reference model tracks writes, out-of-range
//            requests and the clear sweep as a remaining-word count.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regbank_writer;

  localparam int DW = 16;
  localparam int NR = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_valid = 1'b0;
  logic [3:0]    wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          clear_req = 1'b0;
`ifdef REGBANK_BYTE_EN
  logic [1:0]    wr_be = 2'b11;
`endif
  logic          wr_ready, busy, clear_done, wr_err;
  logic [15:0]   wr_onehot;
  logic [16*DW-1:0] regs_o;

  regbank_writer #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
`ifdef REGBANK_BYTE_EN
    .wr_be      (wr_be),
`endif
    .clear_req  (clear_req),
    .busy       (busy),
    .clear_done (clear_done),
    .wr_err     (wr_err),
    .wr_onehot  (wr_onehot),
    .regs_o     (regs_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Reference model state
  logic [DW-1:0] mem [16];
  int            sweep_left;
  logic          exp_done, exp_err;
  logic [15:0]   exp_oh;
  logic          last_acc;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] exp_regs();
    logic [255:0] r;
    for (int i = 0; i < 16; i++) r[i*DW +: DW] = mem[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mem[i] = '0;
    sweep_left = 0;
    exp_done   = 1'b0;
    exp_err    = 1'b0;
    exp_oh     = '0;
    last_acc   = 1'b0;
  endtask

  task automatic check_outputs(input string when);
    check({when, " regs_o"},     regs_o,     exp_regs());
    check({when, " busy"},       busy,       sweep_left > 0);
    check({when, " clear_done"}, clear_done, exp_done);
    check({when, " wr_err"},     wr_err,     exp_err);
    check({when, " wr_onehot"},  wr_onehot,  exp_oh);
  endtask

  // One clock cycle: drive inputs, check ready, take the edge, advance the
  // model by the rules, then compare every registered output.
  task automatic cycle(input logic v, input logic [3:0] a, input logic [DW-1:0] d, input logic c);
    logic rdy;
    wr_valid = v; wr_addr = a; wr_data = d; clear_req = c;
    #1;
    rdy = (sweep_left == 0) && !c;
    check("wr_ready", wr_ready, rdy);
    last_acc = v && rdy;
    @(posedge clk); #1;
    exp_done = 1'b0; exp_err = 1'b0; exp_oh = '0;
    if (sweep_left > 0) begin
      mem[NR - sweep_left] = '0;
      sweep_left--;
      exp_done = (sweep_left == 0);
    end else if (c) begin
      sweep_left = NR;
    end else if (last_acc) begin
      if (int'(a) < NR) begin
`ifdef REGBANK_BYTE_EN
        for (int b = 0; b < 2; b++) if (wr_be[b]) mem[a][b*8 +: 8] = d[b*8 +: 8];
`else
        mem[a] = d;
`endif
        exp_oh = 16'h1 << a;
      end else begin
        exp_err = 1'b1;
      end
    end
    check_outputs("cycle");
  endtask

  initial begin
    logic       pv;
    logic [3:0] pa;
    logic [15:0] pd;
    logic       pc;

    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset wr_ready", wr_ready, 1'b0);
    check_outputs("reset");
    rst_n = 1'b1;

    // Single write, then constant check of the addressed word
    cycle(1'b1, 4'd3, 16'hA5A5, 1'b0);
    check("word3 A5A5", regs_o[3*DW +: DW], 16'hA5A5);
    check("onehot 0008", wr_onehot, 16'h0008);
    cycle(1'b0, 4'd0, 16'h0000, 1'b0);

    // Back-to-back writes, one acceptance per cycle
    for (int i = 0; i < NR; i++) cycle(1'b1, 4'(i), 16'(16'h1000 + i), 1'b0);
    cycle(1'b0, 4'd0, 16'h0000, 1'b0);
    check("word11 100B", regs_o[11*DW +: DW], 16'h100B);

    // Out-of-range write
    cycle(1'b1, 4'd13, 16'hFFFF, 1'b0);
    check("oor wr_err", wr_err, 1'b1);
    check("oor word13", regs_o[13*DW +: DW], 16'h0000);
    cycle(1'b0, 4'd0, 16'h0000, 1'b0);

    // Same address twice: last data wins
    cycle(1'b1, 4'd7, 16'h1111, 1'b0);
    cycle(1'b1, 4'd7, 16'h2222, 1'b0);
    check("word7 last", regs_o[7*DW +: DW], 16'h2222);

    // Fill, then clear with a simultaneous write to 5 held pending
    for (int i = 0; i < NR; i++) cycle(1'b1, 4'(i), 16'(16'hC000 + i), 1'b0);
    cycle(1'b1, 4'd5, 16'h5555, 1'b1);
    for (int k = 0; k < NR; k++) cycle(1'b1, 4'd5, 16'h5555, 1'b0);
    check("clear_done end", clear_done, 1'b1);
    cycle(1'b1, 4'd5, 16'h5555, 1'b0);
    check("pending word5", regs_o[5*DW +: DW], 16'h5555);
    cycle(1'b0, 4'd0, 16'h0000, 1'b0);

    // Reset during the sweep
    for (int i = 0; i < NR; i++) cycle(1'b1, 4'(i), 16'(16'hB000 + i), 1'b0);
    cycle(1'b0, 4'd0, 16'h0000, 1'b1);
    cycle(1'b0, 4'd0, 16'h0000, 1'b1);   // ignored mid-sweep
    for (int k = 0; k < 5; k++) cycle(1'b0, 4'd0, 16'h0000, 1'b0);
    clear_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("midreset");
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post-reset ready", wr_ready, 1'b1);
    check_outputs("post-reset");

`ifdef REGBANK_BYTE_EN
    wr_be = 2'b11;
    cycle(1'b1, 4'd2, 16'h1234, 1'b0);
    wr_be = 2'b10;
    cycle(1'b1, 4'd2, 16'hABCD, 1'b0);
    check("be 10", regs_o[2*DW +: DW], 16'hAB34);
    wr_be = 2'b00;
    cycle(1'b1, 4'd2, 16'hFFFF, 1'b0);
    check("be 00", regs_o[2*DW +: DW], 16'hAB34);
    check("be 00 onehot", wr_onehot, 16'h0004);
`endif

    // Randomized traffic honouring the hold-until-accepted rule
    pv = 1'b0; pa = '0; pd = '0;
    for (int n = 0; n < 400; n++) begin
      if (!pv) begin
        pv = ($urandom_range(0, 3) != 0);
        pa = 4'($urandom_range(0, 15));
        pd = 16'($urandom);
`ifdef REGBANK_BYTE_EN
        wr_be = 2'($urandom_range(0, 3));
`endif
      end
      pc = ($urandom_range(0, 24) == 0);
      cycle(pv, pa, pd, pc);
      if (last_acc) pv = 1'b0;
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
